// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: checks the stream timing, recovers pixel coordinates
// and captures the colour seen at a programmable probe pixel once per frame.
`timescale 1ns/1ps
module vga_rx_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1600
) (
  input  logic       clock_25M,
  input  logic       reset_n,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic       vga_de,
  input  logic [9:0] vga_r,
  input  logic [9:0] vga_g,
  input  logic [9:0] vga_b,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  input  logic       err_clear,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [3:0] err_flags,
  output logic [9:0] probe_r,
  output logic [9:0] probe_g,
  output logic [9:0] probe_b,
  output logic       probe_valid
);
  localparam int HMAX = (TIMEOUT > H_TOTAL) ? TIMEOUT : H_TOTAL;
  localparam int HCW  = $clog2(HMAX + 1);
  localparam int VCW  = $clog2(V_TOTAL + 1);
  localparam int GCW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  function automatic logic [HCW-1:0] sat_h(input logic [HCW-1:0] v);
    return (&v) ? v : v + HCW'(1);
  endfunction

  function automatic logic [VCW-1:0] sat_v(input logic [VCW-1:0] v);
    return (&v) ? v : v + VCW'(1);
  endfunction

  function automatic logic [9:0] sat_c(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  logic           hs_s1, hs_s2, vs_s1, vs_s2, de_s1, de_s2;
  logic [9:0]     r_s1, g_s1, b_s1, r_s2, g_s2, b_s2;
  logic [1:0]     state;
  logic [GCW-1:0] good_cnt;
  logic [HCW-1:0] since_fall, hs_low_cnt, de_cnt;
  logic [VCW-1:0] hfall_cnt, vs_low_lines, de_lines;
  logic           de_seen, primed, frame_err, armed;
  logic [9:0]     probe_xq, probe_yq;
  logic           hs_fall, hs_rise, vs_fall, de_rise, de_fall, new_de_line;
  logic           active, h_chk, timeout_hit, frame_bad, hit;
  logic [3:0]     err_set;

  // s1 -> s2 input stages; idle preset so reset release never looks like an edge
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1 <= 1'b1; hs_s2 <= 1'b1;
      vs_s1 <= 1'b1; vs_s2 <= 1'b1;
      de_s1 <= 1'b0; de_s2 <= 1'b0;
      r_s1  <= '0;   g_s1  <= '0;   b_s1 <= '0;
      r_s2  <= '0;   g_s2  <= '0;   b_s2 <= '0;
    end else begin
      hs_s1 <= vga_hsync; hs_s2 <= hs_s1;
      vs_s1 <= vga_vsync; vs_s2 <= vs_s1;
      de_s1 <= vga_de;    de_s2 <= de_s1;
      r_s1  <= vga_r;     g_s1  <= vga_g;  b_s1 <= vga_b;
      r_s2  <= r_s1;      g_s2  <= g_s1;   b_s2 <= b_s1;
    end
  end

  // Edge detection and timing checks on the s1/s2 pair
  assign hs_fall     = ~hs_s1 & hs_s2;
  assign hs_rise     = hs_s1 & ~hs_s2;
  assign vs_fall     = ~vs_s1 & vs_s2;
  assign de_rise     = de_s1 & ~de_s2;
  assign de_fall     = ~de_s1 & de_s2;
  assign new_de_line = de_rise & ~de_seen;
  assign active      = (state != SEARCH);
  assign h_chk       = active & primed;
  assign timeout_hit = (since_fall >= HCW'(TIMEOUT)) & ~hs_fall;
  assign frame_bad   = frame_err | (|err_set);
  assign hit         = armed & rx_valid & (rx_x == probe_xq) & (rx_y == probe_yq);

  always_comb begin
    err_set    = '0;
    err_set[0] = h_chk & hs_fall & (since_fall != HCW'(H_TOTAL));
    err_set[1] = h_chk & hs_rise & (hs_low_cnt != HCW'(H_SYNC));
    err_set[2] = h_chk & ((de_fall & (de_cnt != HCW'(H_ACTIVE))) | (de_rise & de_seen));
    err_set[3] = active & vs_fall & ((hfall_cnt != VCW'(V_TOTAL)) |
                                     (vs_low_lines != VCW'(V_SYNC)) |
                                     (de_lines != VCW'(V_ACTIVE)));
  end

  // Run-length and per-frame counters
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      since_fall   <= '0;
      hs_low_cnt   <= '0;
      de_cnt       <= '0;
      de_seen      <= 1'b0;
      hfall_cnt    <= '0;
      vs_low_lines <= '0;
      de_lines     <= '0;
      frame_err    <= 1'b0;
      primed       <= 1'b0;
    end else begin
      since_fall <= hs_fall ? HCW'(1) : sat_h(since_fall);
      if (hs_fall)     hs_low_cnt <= HCW'(1);
      else if (!hs_s1) hs_low_cnt <= sat_h(hs_low_cnt);
      if (de_rise)     de_cnt <= HCW'(1);
      else if (de_s1)  de_cnt <= sat_h(de_cnt);
      if (de_rise)      de_seen <= 1'b1;
      else if (hs_fall) de_seen <= 1'b0;
      if (vs_fall) begin
        hfall_cnt    <= VCW'(hs_fall);
        vs_low_lines <= VCW'(hs_fall & ~vs_s1);
        de_lines     <= VCW'(new_de_line);
        frame_err    <= 1'b0;
      end else begin
        if (hs_fall)          hfall_cnt    <= sat_v(hfall_cnt);
        if (hs_fall & ~vs_s1) vs_low_lines <= sat_v(vs_low_lines);
        if (new_de_line)      de_lines     <= sat_v(de_lines);
        frame_err <= frame_err | (|err_set);
      end
      // The first hsync fall after SEARCH only starts the line-period measurement
      primed <= (state == SEARCH) ? 1'b0 : (primed | hs_fall);
    end
  end

  // Lock FSM
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      locked <= (state == LOCKED);
      if (timeout_hit) begin
        state    <= SEARCH;
        good_cnt <= '0;
      end else begin
        case (state)
          SEARCH: if (vs_fall) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
          MEASURE: if (vs_fall) begin
            if (frame_bad) good_cnt <= '0;
            else if ((good_cnt + GCW'(1)) >= GCW'(LOCK_FRAMES)) begin
              state    <= LOCKED;
              good_cnt <= '0;
            end else good_cnt <= good_cnt + GCW'(1);
          end
          LOCKED: if (vs_fall && frame_bad) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Coordinates, error flags and probe capture
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      rx_x        <= '0;
      rx_y        <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      err_flags   <= '0;
      probe_xq    <= '0;
      probe_yq    <= '0;
      armed       <= 1'b0;
      probe_r     <= '0;
      probe_g     <= '0;
      probe_b     <= '0;
      probe_valid <= 1'b0;
    end else begin
      rx_valid    <= de_s1;
      frame_start <= vs_fall;
      if (de_rise)     rx_x <= '0;
      else if (de_s1)  rx_x <= sat_c(rx_x);
      if (vs_fall)      rx_y <= '0;
      else if (de_fall) rx_y <= sat_c(rx_y);
      // A new error event wins over a simultaneous clear
      err_flags   <= (err_clear ? 4'b0000 : err_flags) | err_set;
      probe_valid <= hit;
      if (hit) begin
        probe_r <= r_s2;
        probe_g <= g_s2;
        probe_b <= b_s2;
        armed   <= 1'b0;
      end
      if (vs_fall) begin
        probe_xq <= probe_x;
        probe_yq <= probe_y;
        armed    <= 1'b1;
      end
    end
  end
endmodule
